// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared definitions for the WS2812 chain driver.
//   - ws_state_e       : frame sequencer states
//   - WS_PIX_W         : pixel word width (24, GRB order chosen by the caller)
//   - WS_*_12M         : default bit/latch timing in clocks at 12 MHz
// Optional feature macro used by this slice: WS_BRIGHTNESS_EN.
package ws2812_pkg;

  localparam int WS_PIX_W          = 24;

  // 1.25 us bit, 0.42/0.83 us high times, 50 us latch at 12 MHz
  localparam int WS_BIT_CYCLES_12M = 15;
  localparam int WS_T0H_12M        = 5;
  localparam int WS_T1H_12M        = 10;
  localparam int WS_LATCH_12M      = 600;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_LATCH
  } ws_state_e;

endpackage

// File: rtl/ws2812_chain_driver_if.sv
// ws2812_chain_driver_if: control and frame-store port of the chain driver.
//   start    : frame request (controller -> driver)
//   busy     : frame in progress, latch period included (driver -> controller)
//   done     : one-cycle completion pulse (driver -> controller)
//   pix_req  : one-cycle read strobe (driver -> frame store)
//   pix_addr : pixel index, valid with pix_req (driver -> frame store)
//   pix_data : pixel word, returned the cycle after pix_req (frame store -> driver)
//   bright   : global brightness shift, only when WS_BRIGHTNESS_EN is defined
// Modports: master = driver side, slave = controller/frame-store side.
interface ws2812_chain_driver_if #(
  parameter int AW = 4
);
  import ws2812_pkg::*;

  logic                start;
  logic                busy;
  logic                done;
  logic                pix_req;
  logic [AW-1:0]       pix_addr;
  logic [WS_PIX_W-1:0] pix_data;
`ifdef WS_BRIGHTNESS_EN
  logic [2:0]          bright;

  modport master (input start, input pix_data, input bright,
                  output busy, output done, output pix_req, output pix_addr);
  modport slave  (output start, output pix_data, output bright,
                  input busy, input done, input pix_req, input pix_addr);
`else
  modport master (input start, input pix_data,
                  output busy, output done, output pix_req, output pix_addr);
  modport slave  (output start, output pix_data,
                  input busy, input done, input pix_req, input pix_addr);
`endif

endinterface

// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder: NRZ waveform for one WS2812 bit at a time.
//   clk, rst_n : clock, asynchronous active-low reset
//   bit_start  : begin a bit on this edge (allowed when idle or with bit_last)
//   bit_val    : value of the bit being sent; must stay stable for the whole bit
//   ws_data    : registered serial output, high for T0H/T1H then low
//   bit_last   : high in the final cycle of the current bit
module ws2812_bit_encoder #(
  parameter int BIT_CYCLES = 15,
  parameter int T0H_CYCLES = 5,
  parameter int T1H_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_start,
  input  logic bit_val,
  output logic ws_data,
  output logic bit_last
);

  localparam int CW = $clog2(BIT_CYCLES);

  logic [CW-1:0] cnt_reg, cnt_next, cnt_inc, high_len;
  logic          ws_reg, ws_next;
  logic          active_reg, active_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      ws_reg     <= 1'b0;
      active_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      ws_reg     <= ws_next;
      active_reg <= active_next;
    end
  end

  always_comb begin
    high_len    = bit_val ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES);
    cnt_inc     = cnt_reg + CW'(1);
    bit_last    = active_reg && (cnt_reg == CW'(BIT_CYCLES - 1));
    cnt_next    = cnt_reg;
    ws_next     = ws_reg;
    active_next = active_reg;
    if (bit_start) begin
      // Every bit opens with a high phase, whatever its value
      cnt_next    = '0;
      ws_next     = 1'b1;
      active_next = 1'b1;
    end else if (bit_last) begin
      cnt_next    = '0;
      ws_next     = 1'b0;
      active_next = 1'b0;
    end else if (active_reg) begin
      // Output for the coming cycle: high while its index is below the high time
      cnt_next = cnt_inc;
      ws_next  = (cnt_inc < high_len);
    end
  end

  assign ws_data = ws_reg;

endmodule

// File: rtl/ws2812_chain_driver.sv
// ws2812_chain_driver: sends NUM_LEDS 24-bit pixels, MSB first, as a gap-free
// WS2812 NRZ stream followed by a LATCH_CYCLES low period; one frame per start.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ws2812_chain_driver_if.master (start/busy/done, pixel read port)
//   ws_data    : serial LED data
// Optional feature: WS_BRIGHTNESS_EN adds bus.bright, a per-byte right shift
// applied when a pixel word is captured.
module ws2812_chain_driver
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS     = 16,
  parameter int BIT_CYCLES   = WS_BIT_CYCLES_12M,
  parameter int T0H_CYCLES   = WS_T0H_12M,
  parameter int T1H_CYCLES   = WS_T1H_12M,
  parameter int LATCH_CYCLES = WS_LATCH_12M
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ws2812_chain_driver_if.master         bus,
  output logic                          ws_data
);

  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam logic [AW-1:0] LAST_PIX = AW'(NUM_LEDS - 1);

  if (!(T0H_CYCLES >= 1 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES))
  begin : g_bad_timing
    $error("ws2812_chain_driver: timing must satisfy 1 <= T0H < T1H < BIT_CYCLES");
  end
  if (NUM_LEDS < 1 || LATCH_CYCLES < 1) begin : g_bad_size
    $error("ws2812_chain_driver: NUM_LEDS and LATCH_CYCLES must be at least 1");
  end

  ws_state_e           state_reg, state_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                pix_req_reg, pix_req_next;
  logic [AW-1:0]       pix_addr_reg, pix_addr_next;
  logic                rd_valid_reg;
  logic [WS_PIX_W-1:0] shift_reg, shift_next;
  logic [WS_PIX_W-1:0] shadow_reg, shadow_next;
  logic [4:0]          bit_idx_reg, bit_idx_next;
  logic [AW-1:0]       pix_idx_reg, pix_idx_next;
  logic [LW-1:0]       latch_reg, latch_next;
  logic [WS_PIX_W-1:0] pix_cap;
  logic                bit_start, bit_last;

`ifdef WS_BRIGHTNESS_EN
  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dim
    assign pix_cap[gi*8 +: 8] = bus.pix_data[gi*8 +: 8] >> bus.bright;
  end
`else
  assign pix_cap = bus.pix_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      pix_req_reg  <= 1'b0;
      pix_addr_reg <= '0;
      rd_valid_reg <= 1'b0;
      shift_reg    <= '0;
      shadow_reg   <= '0;
      bit_idx_reg  <= '0;
      pix_idx_reg  <= '0;
      latch_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      pix_req_reg  <= pix_req_next;
      pix_addr_reg <= pix_addr_next;
      // Frame store answers one cycle after the strobe
      rd_valid_reg <= pix_req_reg;
      shift_reg    <= shift_next;
      shadow_reg   <= shadow_next;
      bit_idx_reg  <= bit_idx_next;
      pix_idx_reg  <= pix_idx_next;
      latch_reg    <= latch_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    pix_req_next  = 1'b0;
    pix_addr_next = pix_addr_reg;
    shift_next    = shift_reg;
    shadow_next   = shadow_reg;
    bit_idx_next  = bit_idx_reg;
    pix_idx_next  = pix_idx_reg;
    latch_next    = latch_reg;
    bit_start     = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next    = ST_FETCH;
          busy_next     = 1'b1;
          pix_req_next  = 1'b1;
          pix_addr_next = '0;
        end
      end
      ST_FETCH: begin
        if (rd_valid_reg) begin
          shift_next   = pix_cap;
          bit_idx_next = '0;
          pix_idx_next = '0;
          bit_start    = 1'b1;
          state_next   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Prefetched word arrives during bit 23, well before its boundary
        if (rd_valid_reg) shadow_next = pix_cap;
        if (bit_last) begin
          // Strobe lands in the first cycle of bit 23
          if (bit_idx_reg == 5'd22 && pix_idx_reg != LAST_PIX) begin
            pix_req_next  = 1'b1;
            pix_addr_next = pix_idx_reg + AW'(1);
          end
          if (bit_idx_reg == 5'd23) begin
            if (pix_idx_reg == LAST_PIX) begin
              state_next = ST_LATCH;
              latch_next = LW'(LATCH_CYCLES);
            end else begin
              shift_next   = shadow_reg;
              pix_idx_next = pix_idx_reg + AW'(1);
              bit_idx_next = '0;
              bit_start    = 1'b1;
            end
          end else begin
            shift_next   = shift_reg << 1;
            bit_idx_next = bit_idx_reg + 5'd1;
            bit_start    = 1'b1;
          end
        end
      end
      ST_LATCH: begin
        if (latch_reg == LW'(1)) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          latch_next = latch_reg - LW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  ws2812_bit_encoder #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES)
  ) u_enc (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_start (bit_start),
    .bit_val   (shift_reg[WS_PIX_W-1]),
    .ws_data   (ws_data),
    .bit_last  (bit_last)
  );

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.pix_req  = pix_req_reg;
  assign bus.pix_addr = pix_addr_reg;

endmodule
